// File: rtl/tmr_voter_pkg.sv
// Shared constants for the TMR voter pipeline: function-select encodings and default sizes.
package tmr_voter_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

    localparam logic [1:0] MODE_MAJ = 2'd0;
    localparam logic [1:0] MODE_AND = 2'd1;
    localparam logic [1:0] MODE_OR  = 2'd2;
    localparam logic [1:0] MODE_XOR = 2'd3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/tmr_voter_pipe.sv
// Two-stage valid/ready pipeline voting three operands (MAJ/AND/OR/XOR), with
// disagreement flag and per-input saturating dissent counters in majority mode.
module tmr_voter_pipe
    import tmr_voter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] z,
    input  logic [1:0]       mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] o,
    output logic             out_err,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_x,
    output logic [CNT_W-1:0] cnt_y,
    output logic [CNT_W-1:0] cnt_z
);

    logic             s1_v;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_y;
    logic [WIDTH-1:0] s1_z;
    logic [1:0]       s1_mode;
    logic             s2_v;
    logic [WIDTH-1:0] s2_o;
    logic             s2_err;

    logic             s1_adv;
    logic             s2_adv;
    logic             xfer;
    logic             is_maj;
    logic [WIDTH-1:0] dx;
    logic [WIDTH-1:0] dy;
    logic [WIDTH-1:0] dz;
    logic [WIDTH-1:0] res;
    logic             err;

    assign s2_adv   = !s2_v || out_ready;
    assign s1_adv   = !s1_v || s2_adv;
    assign in_ready = s1_adv && !rst;
    assign xfer     = s1_v && s2_adv;
    assign is_maj   = (s1_mode == MODE_MAJ);

    // A bit's dissenter differs from the other two, which agree with each other.
    assign dx = (s1_x ^ s1_y) & ~(s1_y ^ s1_z);
    assign dy = (s1_y ^ s1_z) & ~(s1_z ^ s1_x);
    assign dz = (s1_z ^ s1_x) & ~(s1_x ^ s1_y);

    always_comb begin
        res = '0;
        err = 1'b0;
        case (s1_mode)
            MODE_MAJ: begin
                res = (s1_x & s1_y) | (s1_y & s1_z) | (s1_x & s1_z);
                err = |(dx | dy | dz);
            end
            MODE_AND: res = s1_x & s1_y & s1_z;
            MODE_OR:  res = s1_x | s1_y | s1_z;
            default:  res = s1_x ^ s1_y ^ s1_z;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v    <= 1'b0;
            s1_x    <= '0;
            s1_y    <= '0;
            s1_z    <= '0;
            s1_mode <= MODE_MAJ;
        end else if (s1_adv) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_x    <= x;
                s1_y    <= y;
                s1_z    <= z;
                s1_mode <= mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v   <= 1'b0;
            s2_o   <= '0;
            s2_err <= 1'b0;
        end else if (s2_adv) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_o   <= res;
                s2_err <= err;
            end
        end
    end

    assign o         = s2_o;
    assign out_err   = s2_err;
    assign out_valid = s2_v;

    sat_counter #(.CNT_W(CNT_W)) u_cnt_x (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (xfer && is_maj && (|dx)),
        .cnt (cnt_x)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_y (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (xfer && is_maj && (|dy)),
        .cnt (cnt_y)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_z (
        .clk (clk),
        .rst (rst),
        .clr (clr_cnt),
        .inc (xfer && is_maj && (|dz)),
        .cnt (cnt_z)
    );

endmodule
